// File: rtl/usb_pkg.sv
// Shared definitions for the USB peripheral: device-class codes, register
// addresses and the CCR select decode.
package usb_pkg;

    typedef enum logic [2:0] {
        CLS_NONE     = 3'd0,
        CLS_AUDIO    = 3'd1,
        CLS_CAMERA   = 3'd2,
        CLS_DISK     = 3'd3,
        CLS_KEYBOARD = 3'd4,
        CLS_SERIAL   = 3'd5
    } usb_class_e;

    localparam int unsigned NUM_CLASSES = 5;

    localparam logic [3:0] RDR_REG = 4'd4;
    localparam logic [3:0] TDR_REG = 4'd8;
    localparam logic [3:0] STA_REG = 4'd12;

    // Codes 5..7 all select the serial class.
    function automatic usb_class_e decode_sel(input logic [2:0] sel);
        usb_class_e cls;
        case (sel)
            3'd0:    cls = CLS_NONE;
            3'd1:    cls = CLS_AUDIO;
            3'd2:    cls = CLS_CAMERA;
            3'd3:    cls = CLS_DISK;
            3'd4:    cls = CLS_KEYBOARD;
            default: cls = CLS_SERIAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/usb_disk_ram.sv
// Byte-wide single-port disk backing RAM with a registered read port.
// Contents start at zero and are not touched by reset.
module usb_disk_ram
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH = 32768,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wen_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH] = '{default: 8'h00};
    logic [7:0] rdata_q;

    // Read-before-write: a same-address write returns the previous byte.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[addr_i];
        if (wen_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_class_mux.sv
// Class selection, pin multiplexing and register-write glue for the USB
// device-class cores. Disk RAM present only when USB_DISK_RAM_EN is defined.
module usb_class_mux
    import usb_pkg::*;
#(
    parameter int unsigned RDR_ADDR   = 4,
    parameter int unsigned STA_ADDR   = 12,
    parameter int unsigned DISK_DEPTH = 32768
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [2:0]  ccr_sel_i,
    input  logic        sta_i,
    output logic [4:0]  cls_rstn_o,
    input  logic [4:0]  cls_pull_i,
    input  logic [4:0]  cls_oe_i,
    input  logic [4:0]  cls_dp_i,
    input  logic [4:0]  cls_dn_i,
    output logic        usb_dp_pull_o,
    inout  wire         usb_dp_io,
    inout  wire         usb_dn_io,
    input  logic        audio_en_i,
    input  logic [31:0] audio_data_i,
    input  logic        camera_sof_i,
    input  logic        camera_req_i,
    output logic        kbd_req_o,
    input  logic        ser_rx_valid_i,
    input  logic [7:0]  ser_rx_data_i,
    input  logic        ser_tx_ready_i,
    output logic        ser_tx_valid_o,
    input  logic [14:0] disk_addr_i,
    input  logic        disk_wen_i,
    input  logic [7:0]  disk_wdata_i,
    output logic [7:0]  disk_rdata_o,
    output logic        reg_we_o,
    output logic [3:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o
);

    localparam logic [3:0] RDR_A = 4'(RDR_ADDR);
    localparam logic [3:0] STA_A = 4'(STA_ADDR);

    usb_class_e state_q, state_d;
    logic       audio_en_prv_q, audio_en_prv_d;
    logic       ser_rx_prv_q, ser_rx_prv_d;
    logic [4:0] sel_onehot_s;
    logic       pin_oe_s;
    logic       pin_dp_s;
    logic       pin_dn_s;

    // Next-state for the selection and the event-delay registers.
    always_comb begin
        state_d        = decode_sel(ccr_sel_i);
        audio_en_prv_d = audio_en_i;
        ser_rx_prv_d   = ser_rx_valid_i;
    end

    // Selection and delayed-event registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= CLS_NONE;
            audio_en_prv_q <= 1'b0;
            ser_rx_prv_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            audio_en_prv_q <= audio_en_prv_d;
            ser_rx_prv_q   <= ser_rx_prv_d;
        end
    end

    // One-hot class decode; all zero when nothing is selected.
    always_comb begin
        sel_onehot_s = 5'b00000;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (state_q == usb_class_e'(3'(k + 1))) begin
                sel_onehot_s[k] = 1'b1;
            end else begin
                sel_onehot_s[k] = 1'b0;
            end
        end
    end

    assign cls_rstn_o    = sel_onehot_s & {5{rstn_i}};
    assign usb_dp_pull_o = |(cls_pull_i & sel_onehot_s);
    assign pin_oe_s      = |(cls_oe_i & sel_onehot_s);
    assign pin_dp_s      = |(cls_dp_i & sel_onehot_s);
    assign pin_dn_s      = |(cls_dn_i & sel_onehot_s);
    assign usb_dp_io     = pin_oe_s ? pin_dp_s : 1'bz;
    assign usb_dn_io     = pin_oe_s ? pin_dn_s : 1'bz;

    // Class events to register-file writes; later rules override earlier ones.
    always_comb begin
        reg_we_o       = 1'b0;
        reg_waddr_o    = RDR_A;
        reg_wdata_o    = 32'h0000_0000;
        kbd_req_o      = 1'b0;
        ser_tx_valid_o = 1'b0;
        case (state_q)
            CLS_AUDIO: begin
                if (audio_en_i) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = RDR_A;
                    reg_wdata_o = audio_data_i;
                end else begin
                    reg_we_o    = reg_we_o;
                end
                if (audio_en_prv_q) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = STA_A;
                    reg_wdata_o = 32'h0000_0000;
                end else begin
                    reg_we_o    = reg_we_o;
                end
            end
            CLS_CAMERA: begin
                if (camera_sof_i || camera_req_i) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = STA_A;
                    reg_wdata_o = 32'h0000_0000;
                end else begin
                    reg_we_o    = 1'b0;
                end
            end
            CLS_KEYBOARD: begin
                if (sta_i) begin
                    kbd_req_o   = 1'b1;
                    reg_we_o    = 1'b1;
                    reg_waddr_o = STA_A;
                    reg_wdata_o = 32'h0000_0000;
                end else begin
                    kbd_req_o   = 1'b0;
                end
            end
            CLS_SERIAL: begin
                ser_tx_valid_o = sta_i;
                if (ser_rx_valid_i) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = RDR_A;
                    reg_wdata_o = {24'h00_0000, ser_rx_data_i};
                end else begin
                    reg_we_o    = reg_we_o;
                end
                if (ser_rx_prv_q) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = STA_A;
                    reg_wdata_o = 32'h0000_0002;
                end else begin
                    reg_we_o    = reg_we_o;
                end
                if (ser_tx_ready_i && sta_i) begin
                    reg_we_o    = 1'b1;
                    reg_waddr_o = STA_A;
                    reg_wdata_o = 32'h0000_0000;
                end else begin
                    reg_we_o    = reg_we_o;
                end
            end
            default: begin
                reg_we_o = 1'b0;
            end
        endcase
        // Reset holds a status clear request and silences core requests.
        if (!rstn_i) begin
            reg_we_o       = 1'b1;
            reg_waddr_o    = STA_A;
            reg_wdata_o    = 32'h0000_0000;
            kbd_req_o      = 1'b0;
            ser_tx_valid_o = 1'b0;
        end else begin
            reg_we_o       = reg_we_o;
        end
    end

`ifdef USB_DISK_RAM_EN
    usb_disk_ram #(
        .DEPTH (DISK_DEPTH),
        .AW    (15)
    ) u_disk_ram (
        .clk_i   (clk_i),
        .addr_i  (disk_addr_i),
        .wen_i   (disk_wen_i),
        .wdata_i (disk_wdata_i),
        .rdata_o (disk_rdata_o)
    );
`else
    logic unused_s;
    assign unused_s     = ^{disk_addr_i, disk_wen_i, disk_wdata_i, 32'(DISK_DEPTH)};
    assign disk_rdata_o = 8'h00;
`endif

endmodule

// File: tb/tb_usb_class_mux.sv
// Directed self-checking bench for usb_class_mux; pins carry pull-ups so
// high-Z reads as 1 and an active low drive reads as 0.
module tb_usb_class_mux;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [2:0]  ccr_sel_i;
    logic        sta_i;
    logic [4:0]  cls_rstn_o;
    logic [4:0]  cls_pull_i, cls_oe_i, cls_dp_i, cls_dn_i;
    logic        usb_dp_pull_o;
    wire         usb_dp_w, usb_dn_w;
    logic        audio_en_i;
    logic [31:0] audio_data_i;
    logic        camera_sof_i, camera_req_i;
    logic        kbd_req_o;
    logic        ser_rx_valid_i;
    logic [7:0]  ser_rx_data_i;
    logic        ser_tx_ready_i;
    logic        ser_tx_valid_o;
    logic [14:0] disk_addr_i;
    logic        disk_wen_i;
    logic [7:0]  disk_wdata_i;
    logic [7:0]  disk_rdata_o;
    logic        reg_we_o;
    logic [3:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    pullup (usb_dp_w);
    pullup (usb_dn_w);

    always #5 clk_i = ~clk_i;

    usb_class_mux dut (
        .clk_i, .rstn_i, .ccr_sel_i, .sta_i, .cls_rstn_o,
        .cls_pull_i, .cls_oe_i, .cls_dp_i, .cls_dn_i, .usb_dp_pull_o,
        .usb_dp_io (usb_dp_w), .usb_dn_io (usb_dn_w),
        .audio_en_i, .audio_data_i, .camera_sof_i, .camera_req_i, .kbd_req_o,
        .ser_rx_valid_i, .ser_rx_data_i, .ser_tx_ready_i, .ser_tx_valid_o,
        .disk_addr_i, .disk_wen_i, .disk_wdata_i, .disk_rdata_o,
        .reg_we_o, .reg_waddr_o, .reg_wdata_o
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [3:0] a, input logic [31:0] d);
        check({tag, "_we"}, 32'(reg_we_o), 32'(we));
        if (we) begin
            check({tag, "_addr"}, 32'(reg_waddr_o), 32'(a));
            check({tag, "_data"}, reg_wdata_o, d);
        end
    endtask

    // Advance past a rising edge; inputs change 2 time units later.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        rstn_i = 1'b0; ccr_sel_i = 3'd7; sta_i = 1'b0;
        cls_pull_i = 5'h1f; cls_oe_i = 5'h1f; cls_dp_i = 5'h00; cls_dn_i = 5'h00;
        audio_en_i = 1'b0; audio_data_i = 32'h0; camera_sof_i = 1'b0; camera_req_i = 1'b0;
        ser_rx_valid_i = 1'b0; ser_rx_data_i = 8'h0; ser_tx_ready_i = 1'b0;
        disk_addr_i = 15'd0; disk_wen_i = 1'b0; disk_wdata_i = 8'h0;

        // Reset behaviour, even with every class driving and a select pending.
        step(); step();
        check_wr("rst", 1'b1, 4'd12, 32'h0);
        check("rst_cls_rstn", 32'(cls_rstn_o), 32'h0);
        check("rst_pull", 32'(usb_dp_pull_o), 32'h0);
        check("rst_dp_hiz", 32'(usb_dp_w), 32'h1);
        check("rst_dn_hiz", 32'(usb_dn_w), 32'h1);
        check("rst_kbd", 32'(kbd_req_o), 32'h0);

        // Release: selection applies only after the next edge.
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        check("sel_pre_cls_rstn", 32'(cls_rstn_o), 32'h00);
        step();
        check("sel7_cls_rstn", 32'(cls_rstn_o), 32'h10);
        cls_pull_i = 5'b10000; #1;
        check("sel7_pull_hi", 32'(usb_dp_pull_o), 32'h1);
        cls_pull_i = 5'b01111; #1;
        check("sel7_pull_lo", 32'(usb_dp_pull_o), 32'h0);
        cls_oe_i = 5'b10000; cls_dp_i = 5'b01111; cls_dn_i = 5'b10000; #1;
        check("sel7_dp_drv", 32'(usb_dp_w), 32'h0);
        check("sel7_dn_drv", 32'(usb_dn_w), 32'h1);
        cls_oe_i = 5'b01111; #1;
        check("sel7_dp_hiz", 32'(usb_dp_w), 32'h1);
        check_wr("ser_idle", 1'b0, 4'd4, 32'h0);

        // Serial receive then delayed status write.
        ser_rx_valid_i = 1'b1; ser_rx_data_i = 8'h41; #1;
        check_wr("ser_rdr", 1'b1, 4'd4, 32'h41);
        step();
        ser_rx_valid_i = 1'b0; #1;
        check_wr("ser_sta2", 1'b1, 4'd12, 32'h2);
        step();
        check_wr("ser_quiet", 1'b0, 4'd4, 32'h0);
        sta_i = 1'b1; #1;
        check("ser_txv", 32'(ser_tx_valid_o), 32'h1);
        check_wr("ser_sta_noready", 1'b0, 4'd4, 32'h0);
        ser_tx_ready_i = 1'b1; ser_rx_valid_i = 1'b1; #1;
        check_wr("ser_tx_prio", 1'b1, 4'd12, 32'h0);
        ser_tx_ready_i = 1'b0; ser_rx_valid_i = 1'b0; sta_i = 1'b0; #1;
        check("ser_txv_lo", 32'(ser_tx_valid_o), 32'h0);

        // Audio.
        ccr_sel_i = 3'd1;
        step(); step();
        check("aud_cls_rstn", 32'(cls_rstn_o), 32'h01);
        sta_i = 1'b1; #1;
        check("aud_no_txv", 32'(ser_tx_valid_o), 32'h0);
        sta_i = 1'b0;
        audio_en_i = 1'b1; audio_data_i = 32'hDEADBEEF; #1;
        check_wr("aud_rdr", 1'b1, 4'd4, 32'hDEADBEEF);
        step();
        audio_en_i = 1'b0; #1;
        check_wr("aud_sta", 1'b1, 4'd12, 32'h0);
        step();
        check_wr("aud_quiet", 1'b0, 4'd4, 32'h0);

        // Keyboard.
        ccr_sel_i = 3'd4;
        step();
        check("kbd_cls_rstn", 32'(cls_rstn_o), 32'h08);
        sta_i = 1'b1; #1;
        check("kbd_req_hi", 32'(kbd_req_o), 32'h1);
        check_wr("kbd_sta", 1'b1, 4'd12, 32'h0);
        sta_i = 1'b0; #1;
        check("kbd_req_lo", 32'(kbd_req_o), 32'h0);
        check_wr("kbd_quiet", 1'b0, 4'd4, 32'h0);

        // Camera.
        ccr_sel_i = 3'd2;
        step();
        camera_sof_i = 1'b1; #1;
        check_wr("cam_sof", 1'b1, 4'd12, 32'h0);
        camera_sof_i = 1'b0; camera_req_i = 1'b1; #1;
        check_wr("cam_req", 1'b1, 4'd12, 32'h0);
        camera_req_i = 1'b0; #1;
        check_wr("cam_quiet", 1'b0, 4'd4, 32'h0);

        // Disk: write 0x5A to 100, read it back.
        ccr_sel_i = 3'd3;
        step();
        check("disk_cls_rstn", 32'(cls_rstn_o), 32'h04);
        disk_addr_i = 15'd100; disk_wdata_i = 8'h5A; disk_wen_i = 1'b1;
        step();
        check("disk_rd_old", 32'(disk_rdata_o), 32'h0);
        disk_wen_i = 1'b0;
        step();
`ifdef USB_DISK_RAM_EN
        check("disk_rd_new", 32'(disk_rdata_o), 32'h5A);
`else
        check("disk_rd_none", 32'(disk_rdata_o), 32'h0);
`endif
        check_wr("disk_quiet", 1'b0, 4'd4, 32'h0);

        // Nothing selected.
        ccr_sel_i = 3'd0; cls_oe_i = 5'h1f; cls_pull_i = 5'h1f; cls_dp_i = 5'h0;
        step();
        check("none_cls_rstn", 32'(cls_rstn_o), 32'h0);
        check("none_pull", 32'(usb_dp_pull_o), 32'h0);
        check("none_dp_hiz", 32'(usb_dp_w), 32'h1);

        // Reset while keyboard is requesting.
        ccr_sel_i = 3'd4;
        step();
        sta_i = 1'b1;
        rstn_i = 1'b0; #1;
        check("rst2_kbd", 32'(kbd_req_o), 32'h0);
        check("rst2_cls_rstn", 32'(cls_rstn_o), 32'h0);
        check_wr("rst2", 1'b1, 4'd12, 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/usb_class_mux.md
# usb_class_mux

Class-selection and glue block of the USB peripheral. It sits between the peripheral register file and the five USB device-class cores: audio, camera, disk, keyboard and serial. It registers the class selection and releases reset only to the selected core. It multiplexes that core's pull-up and D+/D- drive onto the shared pins, and turns class events into register-file write requests. An optional disk backing RAM is included.

## Interface
Parameters:
- RDR_ADDR, 4, receive-data register address
- STA_ADDR, 12, status register address
- DISK_DEPTH, 32768, disk RAM bytes (64 x 512)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous, active-low
- ccr_sel_i  in  3  class select from CCR (0 none, 1 audio, 2 camera, 3 disk, 4 keyboard, 5-7 serial)
- sta_i  in  1  status bit from register file
- cls_rstn_o  out  5  per-class active-low reset; bit k-1 belongs to class k
- cls_pull_i, cls_oe_i, cls_dp_i, cls_dn_i  in  5 each  per-class pull-up, drive enable, D+ and D- drive values
- usb_dp_pull_o  out  1  D+ pull-up
- usb_dp_io, usb_dn_io  inout  1  bus pins
- audio_en_i  in  1  audio sample strobe
- audio_data_i  in  32  audio sample
- camera_sof_i, camera_req_i  in  1  camera frame events
- kbd_req_o  out  1  keyboard request
- ser_rx_valid_i  in  1  serial byte received
- ser_rx_data_i  in  8  received byte
- ser_tx_ready_i  in  1  serial core ready to send
- ser_tx_valid_o  out  1  send request
- disk_addr_i  in  15  disk RAM address
- disk_wen_i  in  1  disk RAM write enable
- disk_wdata_i  in  8  disk RAM write data
- disk_rdata_o  out  8  disk RAM read data
- reg_we_o  out  1  register write request
- reg_waddr_o  out  4  register write address
- reg_wdata_o  out  32  register write data

## Operation
- Selection: state[2:0] <= ccr_sel_i, with 5..7 mapped to 5. Reset value 0.
- Class resets: cls_rstn_o[k-1] = rstn_i & (state==k).
- Pin mux for the selected class: usb_dp_pull_o = cls_pull_i; each pin is driven with cls_dp_i/cls_dn_i when cls_oe_i is 1, else high-Z.
- State 0: no pull-up, both pins high-Z.
- Write-request defaults: we=0, addr=RDR_ADDR, data=0. Later rules below override earlier ones.
- Audio:
  - audio_en_i → write RDR with audio_data_i.
  - audio_en_prv → write STA with 0.
- Camera: camera_sof_i or camera_req_i → write STA with 0.
- Disk: no register writes.
- Keyboard: sta_i → kbd_req_o=1 and write STA with 0.
- Serial:
  - ser_rx_valid_i → write RDR with {24'b0, ser_rx_data_i}.
  - ser_rx_valid_prv → write STA with 2.
  - ser_tx_valid_o = sta_i.
  - ser_tx_ready_i & sta_i → write STA with 0 (this serial rule has the highest priority).
- While rstn_i is low: we=1, addr=STA_ADDR, data=0; kbd_req_o and ser_tx_valid_o are 0.
- Outputs while rstn_i is low: state=0, both *_prv registers=0, cls_rstn_o=0, usb_dp_pull_o=0, pins high-Z.

## Timing
- state and the *_prv registers (one-cycle delayed copies of audio_en_i and ser_rx_valid_i) update on the rising edge of clk_i.
- A select change takes effect one cycle later; the old core enters reset on the same edge.
- Pin mux and write-request logic are purely combinational from state and inputs.
- Disk RAM:
  - Synchronous, one-cycle read latency.
  - A simultaneous read/write of the same address returns the old data.
  - Contents are zero-initialised; reset does not clear them.

## Configuration
- USB_DISK_RAM_EN defined: the internal DISK_DEPTH x 8 RAM is instantiated and addressed by disk_addr_i.
- Not defined: no RAM; disk_rdata_o = 0 and disk writes are ignored.

## Structure
- Shared package usb_pkg holds:
  - class codes (AUDIO=1, CAMERA=2, DISK=3, KEYBOARD=4, SERIAL=5);
  - register addresses (RDR=4, TDR=8, STA=12).
- Sub-module usb_disk_ram is the RAM, used only under USB_DISK_RAM_EN.

## Test plan
- Reset: rstn_i=0 → reg_we_o=1, reg_waddr_o=12, reg_wdata_o=0, cls_rstn_o=0, pins high-Z.
- Selection: ccr_sel_i=7 → one cycle later cls_rstn_o=5'b10000 and usb_dp_pull_o follows cls_pull_i[4].
- Audio: state 1, audio_en_i=1 with data 0xDEADBEEF → RDR write of 0xDEADBEEF; next cycle, with audio_en_i=0, STA write of 0.
- Serial:
  - ser_rx_valid_i with byte 0x41 → RDR write of 0x41, then STA write of 2.
  - sta_i=1 with ser_tx_ready_i=1 → STA write of 0.
- Keyboard: state 4, sta_i=1 → kbd_req_o=1 and STA write of 0; with sta_i=0, reg_we_o=0.
- Disk RAM (USB_DISK_RAM_EN): write 0x5A to address 100 → read of address 100 returns 0x5A one cycle later; without the macro it returns 0.
